// File: rtl/cover_toggle_collector.sv
// Toggle cover collector: records which cover points were hit and, on
// request, walks the hit bitmap and streams the global index of every hit
// point through a valid/ready handshake, optionally clearing each point as
// it leaves.
module cover_toggle_collector #(
  parameter int          WIDTH       = 42,
  parameter int unsigned COVER_INDEX = 0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [WIDTH-1:0]               valid,
  input  logic                           enable,
  input  logic                           drain_req,
  input  logic                           drain_clear,
  output logic                           out_valid,
  output logic [63:0]                    out_index,
  input  logic                           out_ready,
  output logic                           drain_busy,
  output logic                           drain_done,
  output logic [$clog2(WIDTH+1)-1:0]     hit_count
);

  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_stateNext;
  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     w_ptrNext;
  logic              r_clr;
  logic              w_clrNext;
  logic [WIDTH-1:0]  r_hit;
  logic [WIDTH-1:0]  w_setMask;
  logic [WIDTH-1:0]  w_clrMask;
  logic              w_accept;
  logic [CW-1:0]     w_count;

  // The emit handshake completes in the cycle the consumer takes the index.
  assign w_accept = (r_state == EMIT) && out_ready;

  // State, pointer and clear-mode registers for the readout walk.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_clr   <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_ptr   <= w_ptrNext;
      r_clr   <= w_clrNext;
    end
  end

  // Walk one point per cycle, stopping at hit points until they are accepted.
  always_comb begin
    w_stateNext = r_state;
    w_ptrNext   = r_ptr;
    w_clrNext   = r_clr;
    w_clrMask   = '0;
    out_valid   = 1'b0;
    out_index   = 64'd0;
    drain_busy  = 1'b0;
    drain_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (drain_req) begin
          w_stateNext = SCAN;
          w_ptrNext   = '0;
          w_clrNext   = drain_clear;
        end
      end
      SCAN: begin
        drain_busy = 1'b1;
        if (r_hit[r_ptr]) begin
          w_stateNext = EMIT;
        end else if (r_ptr == LAST_PTR) begin
          w_stateNext = DONE;
        end else begin
          w_ptrNext = r_ptr + 1'b1;
        end
      end
      EMIT: begin
        drain_busy = 1'b1;
        out_valid  = 1'b1;
        out_index  = 64'(COVER_INDEX) + 64'(r_ptr);
        if (w_accept) begin
          if (r_clr) begin
            w_clrMask[r_ptr] = 1'b1;
          end
          if (r_ptr == LAST_PTR) begin
            w_stateNext = DONE;
          end else begin
            w_ptrNext   = r_ptr + 1'b1;
            w_stateNext = SCAN;
          end
        end
      end
      DONE: begin
        drain_busy  = 1'b1;
        drain_done  = 1'b1;
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  assign w_setMask = enable ? valid : '0;

  // Hit bitmap: a new hit in the same cycle as a drain clear keeps the bit set.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hit <= '0;
    end else begin
      r_hit <= (r_hit & ~w_clrMask) | w_setMask;
    end
  end

  // Population count of the bitmap, combinational so it tracks r_hit exactly.
  always_comb begin
    w_count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_count = w_count + CW'(r_hit[i]);
    end
  end

  assign hit_count = w_count;

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Bench for cover_toggle_collector: a bitmap model plus a queue of expected
// emitted indices, filled as hits are driven and drained as beats are taken.
module tb_cover_toggle_collector;

  localparam int W  = 42;
  localparam int CI = 100;

  logic          clock = 1'b0;
  logic          reset;
  logic [W-1:0]  valid;
  logic          enable;
  logic          drain_req;
  logic          drain_clear;
  logic          out_valid;
  logic [63:0]   out_index;
  logic          out_ready;
  logic          drain_busy;
  logic          drain_done;
  logic [5:0]    hit_count;

  int            checkCount = 0;
  int            errorCount = 0;
  logic [63:0]   expQ[$];
  logic [W-1:0]  modelHits;

  cover_toggle_collector #(.WIDTH(W), .COVER_INDEX(CI)) dut (
    .clock(clock), .reset(reset), .valid(valid), .enable(enable),
    .drain_req(drain_req), .drain_clear(drain_clear),
    .out_valid(out_valid), .out_index(out_index), .out_ready(out_ready),
    .drain_busy(drain_busy), .drain_done(drain_done), .hit_count(hit_count)
  );

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Pulses a valid pattern for one cycle and records the points it adds.
  task automatic applyStimulus(input logic [W-1:0] mask);
    valid  = mask;
    enable = 1'b1;
    for (int b = 0; b < W; b++) begin
      if (mask[b] && !modelHits[b]) expQ.push_back(64'(CI + b));
    end
    modelHits = modelHits | mask;
    expQ.sort();
    @(negedge clock);
    valid = '0;
  endtask

  task automatic applyReset();
    reset = 1'b0;
    @(negedge clock);
    reset     = 1'b1;
    modelHits = '0;
    expQ.delete();
  endtask

  // One readout pass with an optional stall and an optional hit injection
  // in the accept cycle of a chosen point.
  task automatic runPass(input logic clr, input int stallIdx, input int stallCycles,
                         input int injIdx, input logic [W-1:0] injMask);
    int stallLeft = stallCycles;
    bit finished  = 0;
    int p;
    drain_req   = 1'b1;
    drain_clear = clr;
    @(negedge clock);
    drain_req   = 1'b0;
    drain_clear = 1'b0;
    for (int c = 0; c < 400 && !finished; c++) begin
      valid     = '0;
      out_ready = 1'b1;
      checkOutput("hit_count_pass", 64'(hit_count), 64'($countones(modelHits)));
      if (drain_done) begin
        finished = 1;
      end else if (out_valid) begin
        p = int'(out_index) - CI;
        if (p == stallIdx && stallLeft > 0) begin
          out_ready = 1'b0;
          stallLeft--;
          checkOutput("stall_index", out_index, 64'(CI + stallIdx));
        end else begin
          if (expQ.size() == 0) checkOutput("unexpected_emit", out_index, 64'hFFFF_FFFF_FFFF_FFFF);
          else checkOutput("emit_index", out_index, expQ.pop_front());
          if (clr && p >= 0 && p < W) modelHits[p] = 1'b0;
          if (p == injIdx) begin
            valid = injMask;
            for (int b = 0; b < W; b++) begin
              if (injMask[b] && !modelHits[b] && b > p) expQ.push_back(64'(CI + b));
            end
            modelHits = modelHits | injMask;
            expQ.sort();
          end
        end
      end
      @(negedge clock);
    end
    valid = '0;
    checkOutput("pass_done", 64'(finished), 64'd1);
    checkOutput("queue_empty", 64'(expQ.size()), 64'd0);
    checkOutput("busy_after", 64'(drain_busy), 64'd0);
    checkOutput("hit_count_after", 64'(hit_count), 64'($countones(modelHits)));
  endtask

  initial begin
    reset = 1'b0; valid = '0; enable = 1'b0; drain_req = 1'b0;
    drain_clear = 1'b0; out_ready = 1'b1; modelHits = '0;
    #12;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_busy", 64'(drain_busy), 64'd0);
    checkOutput("rst_done", 64'(drain_done), 64'd0);
    checkOutput("rst_index", out_index, 64'd0);
    checkOutput("rst_hit_count", 64'(hit_count), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    // Bits 0 and 41, then the same pattern again.
    applyStimulus((W'(1) << 0) | (W'(1) << 41));
    checkOutput("hit_count_two", 64'(hit_count), 64'd2);
    applyStimulus((W'(1) << 0) | (W'(1) << 41));
    checkOutput("hit_count_repeat", 64'(hit_count), 64'd2);
    applyReset();
    checkOutput("hit_count_cleared", 64'(hit_count), 64'd0);

    // Empty pass: busy for cycles 1..43, done only in 43.
    drain_req = 1'b1;
    @(negedge clock);
    drain_req = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      checkOutput($sformatf("empty_busy_c%0d", c), 64'(drain_busy), 64'(c <= W + 1));
      checkOutput($sformatf("empty_done_c%0d", c), 64'(drain_done), 64'(c == W + 1));
      checkOutput($sformatf("empty_ov_c%0d", c), 64'(out_valid), 64'd0);
      @(negedge clock);
    end

    // Clearing pass over {3,17}.
    applyStimulus((W'(1) << 3) | (W'(1) << 17));
    runPass(1'b1, -1, 0, -1, '0);

    // Same, with a five-cycle stall at point 3.
    applyStimulus((W'(1) << 3) | (W'(1) << 17));
    runPass(1'b1, 3, 5, -1, '0);

    // Re-hit of point 17 in its own accept cycle survives the clear.
    applyStimulus((W'(1) << 3) | (W'(1) << 17) | (W'(1) << 20));
    runPass(1'b1, -1, 0, 17, W'(1) << 17);
    checkOutput("set_wins", 64'(hit_count), 64'd1);

    // Non-clearing pass; hits behind and ahead of the pointer mid-pass.
    applyReset();
    applyStimulus(W'(1) << 10);
    runPass(1'b0, -1, 0, 10, (W'(1) << 2) | (W'(1) << 30));
    checkOutput("mid_pass_hits", 64'(hit_count), 64'd3);

    // Reset asserted while a point is being offered.
    out_ready   = 1'b0;
    drain_req   = 1'b1;
    drain_clear = 1'b1;
    @(negedge clock);
    drain_req = 1'b0;
    for (int c = 0; c < 100 && !out_valid; c++) @(negedge clock);
    checkOutput("reached_emit", 64'(out_valid), 64'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
    checkOutput("abort_busy", 64'(drain_busy), 64'd0);
    checkOutput("abort_hit_count", 64'(hit_count), 64'd0);
    checkOutput("abort_index", out_index, 64'd0);
    @(negedge clock);
    reset = 1'b1; out_ready = 1'b1; modelHits = '0; expQ.delete();
    for (int c = 0; c < 5; c++) begin
      checkOutput("abort_no_done", 64'(drain_done), 64'd0);
      @(negedge clock);
    end
    applyStimulus(W'(1) << 7);
    checkOutput("post_reset_hit", 64'(hit_count), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
